// File: rtl/lif_pkg.sv
// Shared constants and the saturating adder for the LIF neuron array.
package lif_pkg;

    localparam int LIF_WIDTH        = 8;
    localparam int LIF_THRESH_RESET = 127;

    // Adds two values of up to 32 bits and clamps the result to 2^w-1.
    // The extra carry bit keeps the sum from wrapping before the clamp.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter,
// threshold comparator and next-state mux. Fire/inhibit decisions come from
// the array so that lateral inhibition stays outside the neuron.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int WIDTH         = LIF_WIDTH,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] thresh,
    input  logic             fire,
    input  logic             inhibit,
    output logic             raw,
    output logic [WIDTH-1:0] state,
    output logic             refractory
);

    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    logic [CNT_W-1:0] refrac_cnt;
    logic [WIDTH-1:0] integ;

    // Leaked state plus input current, clamped at full scale.
    always_comb begin
        integ = WIDTH'(sat_add(32'(current), 32'(state >> LEAK_SHIFT), WIDTH));
    end

    // Spike candidate uses registered state only, so current never reaches spike combinationally.
    assign raw        = en && (refrac_cnt == '0) && (state >= thresh);
    assign refractory = (refrac_cnt != '0);

    // State/refractory update: fire, then inhibit, then refractory hold, then integrate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= '0;
            refrac_cnt <= '0;
        end else if (en) begin
            if (fire) begin
                state      <= '0;
                refrac_cnt <= CNT_W'(REFRAC_CYCLES);
            end else if (inhibit) begin
                state <= '0;
            end else if (refrac_cnt != '0) begin
                state      <= '0;
                refrac_cnt <= refrac_cnt - 1'b1;
            end else begin
                state <= integ;
            end
        end
    end

endmodule

// File: rtl/lif_wta_array.sv
// Array of LIF neurons with run-time threshold, optional winner-take-all
// lateral inhibition and a saturating count of cycles that produced a spike.
module lif_wta_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int WIDTH         = LIF_WIDTH,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 2,
    parameter int THRESH_RESET  = LIF_THRESH_RESET,
    parameter int INHIBIT       = 1,
    localparam int IDX_W        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_NEURONS*WIDTH-1:0] current,
    input  logic                       thresh_wr,
    input  logic [WIDTH-1:0]           thresh_data,
    output logic [N_NEURONS-1:0]       spike,
    output logic                       winner_valid,
    output logic [IDX_W-1:0]           winner_idx,
    output logic [N_NEURONS*WIDTH-1:0] state,
    output logic [N_NEURONS-1:0]       refractory,
    output logic [15:0]                spike_count
);

    logic [WIDTH-1:0]     thresh;
    logic [N_NEURONS-1:0] raw;
    logic [N_NEURONS-1:0] loser;

    // Output qualifier: winner_idx is meaningful only while winner_valid is
    // high (it reads 0 otherwise); there is no ready/backpressure, the result
    // is a per-cycle snapshot consumed by the downstream logic.
    assign winner_valid = |raw;

    // Priority encoder: lowest-index candidate wins.
    always_comb begin
        winner_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (raw[i]) winner_idx = IDX_W'(i);
        end
    end

    generate
        if (INHIBIT != 0) begin : g_wta
            // Isolate the lowest set bit; every other neuron is a loser when anyone fires.
            assign spike = raw & (~raw + 1'b1);
            assign loser = winner_valid ? ~spike : '0;
        end else begin : g_indep
            assign spike = raw;
            assign loser = '0;
        end
    endgenerate

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lif_neuron #(
            .WIDTH         (WIDTH),
            .LEAK_SHIFT    (LEAK_SHIFT),
            .REFRAC_CYCLES (REFRAC_CYCLES)
        ) u_neuron (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .current    (current[g*WIDTH +: WIDTH]),
            .thresh     (thresh),
            .fire       (spike[g]),
            .inhibit    (loser[g]),
            .raw        (raw[g]),
            .state      (state[g*WIDTH +: WIDTH]),
            .refractory (refractory[g])
        );
    end

    // Threshold register: loads regardless of en; the new value is seen from the next cycle.
    always_ff @(posedge clk) begin
        if (rst)            thresh <= WIDTH'(THRESH_RESET);
        else if (thresh_wr) thresh <= thresh_data;
    end

    // Saturating count of cycles with a winner.
    always_ff @(posedge clk) begin
        if (rst)                                     spike_count <= '0;
        else if (winner_valid && spike_count != '1) spike_count <= spike_count + 16'd1;
    end

endmodule

// File: tb/tb_lif_wta_array.sv
// Directed bench for lif_wta_array: one WTA instance (a) and one independent
// instance (b) share all inputs; expected values are hand-computed.
module tb_lif_wta_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] current;
    logic        thresh_wr;
    logic [7:0]  thresh_data;

    logic [3:0]  a_spike, b_spike;
    logic        a_wv, b_wv;
    logic [1:0]  a_idx, b_idx;
    logic [31:0] a_state, b_state;
    logic [3:0]  a_refr, b_refr;
    logic [15:0] a_cnt, b_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lif_wta_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_CYCLES(2),
                    .THRESH_RESET(127), .INHIBIT(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .current(current),
        .thresh_wr(thresh_wr), .thresh_data(thresh_data),
        .spike(a_spike), .winner_valid(a_wv), .winner_idx(a_idx),
        .state(a_state), .refractory(a_refr), .spike_count(a_cnt)
    );

    lif_wta_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_CYCLES(2),
                    .THRESH_RESET(127), .INHIBIT(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .current(current),
        .thresh_wr(thresh_wr), .thresh_data(thresh_data),
        .spike(b_spike), .winner_valid(b_wv), .winner_idx(b_idx),
        .state(b_state), .refractory(b_refr), .spike_count(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        current = {c3, c2, c1, c0};
    endtask

    initial begin
        int exp_s [7];
        exp_s = '{64, 96, 112, 120, 124, 126, 127};

        rst = 1'b1; en = 1'b0; current = '0; thresh_wr = 1'b0; thresh_data = '0;
        #1;
        // Reset
        step(); step();
        check("rst_state", a_state, 0);
        check("rst_spike", a_spike, 0);
        check("rst_wv", a_wv, 0);
        check("rst_idx", a_idx, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_refr", a_refr, 0);

        rst = 1'b0; en = 1'b1;
        step();
        check("idle_state", a_state, 0);
        check("idle_spike", a_spike, 0);

        // Integration towards threshold 127
        set_cur(64, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("integ_s%0d", k), a_state[7:0], exp_s[k]);
            check($sformatf("integ_spk%0d", k), a_spike, (k == 6) ? 4'b0001 : 4'b0000);
        end
        check("fire_wv", a_wv, 1);
        check("fire_idx", a_idx, 0);

        // Refractory: flag high for two cycles, state held at 0
        step();
        check("refr1_state", a_state, 0);
        check("refr1_flag", a_refr, 4'b0001);
        check("refr1_cnt", a_cnt, 1);
        step();
        check("refr2_state", a_state, 0);
        check("refr2_flag", a_refr, 4'b0001);
        step();
        check("refr3_state", a_state, 0);
        check("refr3_flag", a_refr, 4'b0000);
        step();
        check("resume_64", a_state[7:0], 64);
        step();
        check("resume_96", a_state[7:0], 96);

        // Enable low holds state at 96
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold_s%0d", k), a_state[7:0], 96);
            check($sformatf("hold_spk%0d", k), a_spike, 0);
        end
        check("hold_wv", a_wv, 0);
        en = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("refire_state", a_state[7:0], 127);
        check("refire_spk", a_spike, 4'b0001);

        // Enable low mid-refractory freezes the counter
        step();
        check("mid_refr_a", a_refr, 4'b0001);
        check("mid_cnt", a_cnt, 2);
        step();
        check("mid_refr_b", a_refr, 4'b0001);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("frz_refr%0d", k), a_refr, 4'b0001);
            check($sformatf("frz_state%0d", k), a_state, 0);
        end
        check("frz_cnt", a_cnt, 2);
        en = 1'b1;
        step();
        check("unfrz_refr", a_refr, 4'b0000);
        check("unfrz_state", a_state, 0);
        step();
        check("unfrz_64", a_state[7:0], 64);

        // Threshold write: old value during the write cycle, new value after
        thresh_wr = 1'b1; thresh_data = 8'd50;
        #1;
        check("thr_old", a_spike, 0);
        step();
        thresh_wr = 1'b0;
        check("thr_new_state", a_state[7:0], 96);
        check("thr_new_spk", a_spike, 4'b0001);
        step();
        check("thr_refr", a_refr, 4'b0001);
        check("thr_cnt", a_cnt, 3);

        // Reset mid-operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_state", a_state, 0);
        check("rst2_refr", a_refr, 0);
        check("rst2_cnt", a_cnt, 0);
        set_cur(100, 0, 0, 0);
        step();
        check("rst2_integ", a_state[7:0], 100);
        check("rst2_thr127", a_spike, 0);

        // Saturation at threshold 255
        thresh_wr = 1'b1; thresh_data = 8'd255;
        set_cur(0, 0, 0, 0);
        step();
        thresh_wr = 1'b0;
        check("sat_leak0", a_state[7:0], 50);
        set_cur(0, 0, 200, 0);
        step();
        check("sat_s1", a_state[23:16], 200);
        check("sat_spk0", a_spike, 0);
        step();
        check("sat_s2", a_state[23:16], 255);
        check("sat_n0", a_state[7:0], 12);
        check("sat_spk", a_spike, 4'b0100);
        check("sat_idx", a_idx, 2);
        check("sat_spk_b", b_spike, 4'b0100);
        set_cur(0, 0, 0, 0);
        step();
        check("sat_after", a_state[23:16], 0);
        check("sat_refr", a_refr, 4'b0100);

        // Simultaneous fire: WTA (a) vs independent (b)
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_cur(0, 200, 0, 200);
        step();
        check("sim_state", a_state, 32'hC800_C800);
        check("sim_spk_a", a_spike, 4'b0010);
        check("sim_idx_a", a_idx, 1);
        check("sim_wv_a", a_wv, 1);
        check("sim_spk_b", b_spike, 4'b1010);
        check("sim_idx_b", b_idx, 1);
        set_cur(0, 0, 0, 0);
        step();
        check("sim_after_a", a_state, 0);
        check("sim_refr_a", a_refr, 4'b0010);
        check("sim_after_b", b_state, 0);
        check("sim_refr_b", b_refr, 4'b1010);

        // Threshold 0: every non-refractory neuron is a candidate
        thresh_wr = 1'b1; thresh_data = 8'd0;
        step();
        thresh_wr = 1'b0;
        check("t0_spk_a", a_spike, 4'b0001);
        check("t0_idx_a", a_idx, 0);
        check("t0_spk_b", b_spike, 4'b0101);
        check("t0_cnt_a", a_cnt, 1);
        step();
        check("t0_cnt_a2", a_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_wta_array.md
Name: lif_wta_array

Overview:
- Parametrised array of leaky integrate-and-fire neurons with a configurable leak shift, run-time threshold, refractory period, saturating integration and optional winner-take-all lateral inhibition.
- Successor to the single 8-bit LIF neuron.
- Sits between the input current encoder and the spike/winner output logic of the WTA design.

Parameters:
- N_NEURONS, 4, number of neurons (2..16).
- WIDTH, 8, bits per current and per membrane state.
- LEAK_SHIFT, 1, leak as a right shift of state (beta = 2^-LEAK_SHIFT); must be 1..WIDTH-1.
- REFRAC_CYCLES, 2, enabled cycles a fired neuron is held at 0 (0 disables refractory).
- THRESH_RESET, 127, threshold value after reset; must be >= 1.
- INHIBIT, 1, 1 = winner-take-all (lowest-index spiking neuron wins, all others cleared); 0 = independent neurons.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, integration enable; 0 freezes all state.
- current, input, N_NEURONS*WIDTH, packed per-neuron input current, neuron i at [i*WIDTH +: WIDTH].
- thresh_wr, input, 1, load threshold strobe.
- thresh_data, input, WIDTH, new threshold value.
- spike, output, N_NEURONS, per-neuron spike this cycle.
- winner_valid, output, 1, at least one spike this cycle.
- winner_idx, output, max(1,$clog2(N_NEURONS)), lowest-index spiking neuron (0 when !winner_valid).
- state, output, N_NEURONS*WIDTH, packed membrane states (registered).
- refractory, output, N_NEURONS, neuron i refractory counter non-zero.
- spike_count, output, 16, count of cycles with winner_valid, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at edge, overrides all else): all state=0, refractory counters=0, threshold=THRESH_RESET, spike_count=0. Hence spike=0, winner_valid=0, winner_idx=0.
- raw[i] = en && refrac_cnt[i]==0 && state[i] >= threshold. Combinational from registered state/threshold only; no current-to-spike path.
- INHIBIT=1: spike = one-hot of the lowest index set in raw.
- INHIBIT=0: spike = raw.
- winner_valid = |raw. winner_idx = priority-encoded lowest index of raw, in both modes.
- Per-neuron next state, enabled cycle, first match wins:
  1. spike[i]=1: state <= 0, refrac_cnt <= REFRAC_CYCLES.
  2. INHIBIT=1, winner_valid=1, spike[i]=0 (loser): state <= 0, refrac_cnt unchanged.
  3. refrac_cnt[i] != 0: state <= 0, refrac_cnt decrements, current ignored.
  4. Otherwise: state <= sat(current[i] + (state[i] >> LEAK_SHIFT)).
- sat: the add is computed at WIDTH+1 bits and clamps to 2^WIDTH-1 on carry; no wrap-around.
- Latency: current sampled at edge k appears in state after edge k; the resulting spike is visible in the same cycle, before edge k+1.
- en=0: state, refrac_cnt and spike_count hold; spike=0, winner_valid=0. Threshold writes are still accepted.
- Threshold: thresh_wr=1 loads thresh_data at the edge. Comparisons in the cycle of the write use the old value; the new value applies from the next cycle. thresh_data=0 is legal: every non-refractory neuron spikes each enabled cycle.
- spike_count: increments at each edge with winner_valid=1 and stops at 0xFFFF.

Decomposition:
- Package lif_pkg: default WIDTH/threshold constants and a saturating-add function parametrised on width.
- Sub-module lif_neuron: one neuron holding state, refractory counter, comparator and the next-state mux. Inputs fire/inhibit come from the top.
- Top lif_wta_array: generate loop of lif_neuron, priority encoder, inhibit logic, threshold register and spike_count.

Test Plan:
All scenarios use N_NEURONS=4, WIDTH=8, LEAK_SHIFT=1, REFRAC_CYCLES=2, INHIBIT=1 unless stated.
1. Reset: rst=1 for 2 cycles, then en=1, current=0 -> state all 0, spike=0000, winner_valid=0, spike_count=0, threshold 127 (no spike at state 126).
2. Integration and refractory: current[0]=64, others 0, en=1.
   - State[0] after successive edges: 64, 96, 112, 120, 124, 126, 127.
   - At 127: spike=0001, winner_idx=0.
   - Next edge: state 0, refractory[0]=1. State stays 0 for 2 enabled cycles, then resumes at 64.
   - spike_count=1.
3. Saturation: write threshold 255, then current[2]=200 -> state 200, then 255 (not 44) -> spike=0100, winner_idx=2.
4. Simultaneous fire, INHIBIT=1: preload neurons 1 and 3 above 127 in the same cycle.
   - spike=0010, winner_idx=1.
   - Next edge: all states 0, only refractory[1]=1.
   - Repeat with INHIBIT=0: spike=1010, winner_idx=1, refractory=1010.
5. Enable hold: at state[0]=96, drop en for 5 cycles -> state 96 held, spike=0.
   - Drop en mid-refractory: counter frozen, and the same number of cycles at 0 remains after en returns.
6. Reset mid-operation: assert rst while refractory[0]=1 and threshold=50 -> next cycle all state 0, refractory 0, threshold 127, spike_count 0. Integration restarts the following edge.
